// File: rtl/dlatch_bank.sv
// dlatch_bank: a bank of DEPTH words, each WIDTH bits wide, with a valid
// flag per entry. All state is edge-triggered on clk, and reset is
// asynchronous and active-low.
//
// Operating modes:
//   00  hold
//   01  addressed write
//   10  shift towards entry DEPTH-1
//   11  synchronous clear
//
// Read side:
//   dout / dout_n  entry[raddr] and its complement (combinational read).
//                  An out-of-range raddr reads as zero.
//   valid          per-entry valid flags.
//   count          popcount of valid.
//
// Shift-out side:
//   so_data        last valid word shifted out of entry DEPTH-1.
//   so_valid       one-cycle pulse after a shift that pushed out a valid word.
//
// Ports:
//   clk      input   1      clock
//   reset    input   1      asynchronous active-low reset
//   mode     input   2      operating mode
//   waddr    input   AW     write address (mode 01)
//   din      input   WIDTH  write data / shift-in data
//   raddr    input   AW     read address
//   dout     output  WIDTH  read data
//   dout_n   output  WIDTH  complement of dout
//   valid    output  DEPTH  valid flags
//   count    output  CW     number of valid entries
//   so_data  output  WIDTH  shifted-out word
//   so_valid output  1      shifted-out word strobe
module dlatch_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] din,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_n,
  output logic [DEPTH-1:0] valid,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] so_data,
  output logic             so_valid
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_WRITE = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

  // One extra bit so that DEPTH itself is representable for the range checks.
  localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] so_data_q, so_data_d;
  logic             so_valid_q, so_valid_d;

  logic             waddr_ok_s;
  logic             raddr_ok_s;
  logic [WIDTH-1:0] dout_s;
  logic [CW-1:0]    count_s;

  // The address width can be wider than the entry range when DEPTH is not a
  // power of two, so both addresses are range-checked.
  assign waddr_ok_s = ({1'b0, waddr} < DEPTH_LIM);
  assign raddr_ok_s = ({1'b0, raddr} < DEPTH_LIM);

  // Next-state logic for the array, the valid flags and the shift-out register.
  always_comb begin
    mem_d      = mem_q;
    valid_d    = valid_q;
    so_data_d  = so_data_q;
    so_valid_d = 1'b0;
    case (mode)
      MODE_HOLD: begin
        so_valid_d = 1'b0;
      end
      MODE_WRITE: begin
        if (waddr_ok_s) begin
          mem_d[waddr]   = din;
          valid_d[waddr] = 1'b1;
        end else begin
          valid_d = valid_q;
        end
      end
      MODE_SHIFT: begin
        for (int i = DEPTH - 1; i >= 1; i--) begin
          mem_d[i]   = mem_q[i-1];
          valid_d[i] = valid_q[i-1];
        end
        mem_d[0]   = din;
        valid_d[0] = 1'b1;
        so_valid_d = valid_q[DEPTH-1];
        // A word that was never valid does not overwrite the last good
        // shifted-out word.
        if (valid_q[DEPTH-1]) begin
          so_data_d = mem_q[DEPTH-1];
        end else begin
          so_data_d = so_data_q;
        end
      end
      MODE_CLEAR: begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_d[i] = '0;
        end
        valid_d = '0;
      end
      default: begin
        so_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q    <= '0;
      so_data_q  <= '0;
      so_valid_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      valid_q    <= valid_d;
      so_data_q  <= so_data_d;
      so_valid_q <= so_valid_d;
    end
  end

  // Combinational read port; an out-of-range address reads as zero.
  always_comb begin
    if (raddr_ok_s) begin
      dout_s = mem_q[raddr];
    end else begin
      dout_s = '0;
    end
  end

  // Popcount of the valid flags.
  always_comb begin
    count_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_s = count_s + CW'(valid_q[i]);
    end
  end

  assign dout     = dout_s;
  assign dout_n   = ~dout_s;
  assign valid    = valid_q;
  assign count    = count_s;
  assign so_data  = so_data_q;
  assign so_valid = so_valid_q;

endmodule

// File: doc/dlatch_bank.md
# dlatch_bank

Parametrised successor to the single-bit gated D storage cell: a bank of DEPTH words, each WIDTH bits, with per-entry valid flags, complementary read outputs and four operating modes (hold, addressed write, shift, synchronous clear). It sits in the memory/latch library as the general-purpose small storage element for register banks, delay lines and staging buffers. All state is edge-triggered on one clock. Reset is asynchronous.

## Interface
- WIDTH, 8, data bits per entry (>= 1)
- DEPTH, 4, number of entries (>= 2)
- AW, derived = max(1, clog2(DEPTH)), address width; not overridden
- CW, derived = clog2(DEPTH+1), count width; not overridden

- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low; clears all state while low
- mode  input  2  00 hold, 01 write, 10 shift, 11 clear
- waddr  input  AW  entry written in mode 01
- din  input  WIDTH  write data (mode 01) or shift-in data (mode 10)
- raddr  input  AW  read address
- dout  output  WIDTH  contents of entry raddr (combinational read)
- dout_n  output  WIDTH  bitwise complement of dout
- valid  output  DEPTH  per-entry valid flags
- count  output  CW  number of set bits in valid
- so_data  output  WIDTH  word shifted out of entry DEPTH-1 (registered)
- so_valid  output  1  one-cycle pulse: so_data holds a valid shifted-out word

## Operation
- reset low: every entry = 0, valid = 0, count = 0, so_data = 0, so_valid = 0. dout = 0 and dout_n = all-ones as a consequence. Assertion takes effect immediately. Deassertion is synchronised to clk upstream. The first active edge after release is an ordinary cycle.
- mode 00 (hold): array and valid unchanged; so_valid <= 0; so_data holds.
- mode 01 (write): if waddr < DEPTH: entry[waddr] <= din, valid[waddr] <= 1. If waddr >= DEPTH: no state change. so_valid <= 0.
- mode 10 (shift): for i = DEPTH-1 down to 1, entry[i] <= entry[i-1] and valid[i] <= valid[i-1]. entry[0] <= din and valid[0] <= 1. so_data <= old entry[DEPTH-1], so_valid <= old valid[DEPTH-1]. An invalid word shifted out does not update so_data.
- mode 11 (clear): all entries <= 0, valid <= 0, so_valid <= 0; so_data holds.
- Read: dout = entry[raddr] when raddr < DEPTH, else 0. dout_n = ~dout at all times, including the out-of-range case (all-ones).
- count: combinational popcount of valid. Range 0..DEPTH; it saturates naturally at DEPTH during repeated shifts.
- Writes do not affect so_data/so_valid. A write never clears a valid bit. Only clear or reset does.

## Timing
- Write/shift/clear visible on dout, valid and count immediately after the capturing edge (one-cycle write-to-read latency). The read is combinational, so a read in the same cycle as a write returns the old value.
- so_valid is high for exactly the one cycle following a shift edge whose old valid[DEPTH-1] = 1. Back-to-back shifts with a full bank give so_valid high continuously.
- Shift with the bank full: the oldest word leaves on so_data, count stays DEPTH.
- Reset asserted mid-shift or mid-write: the in-flight update is discarded and all outputs show their reset values within the same cycle.
- mode changes take effect on the next edge. There is no multi-cycle operation and no internal FSM beyond the array/valid state and the so_* register.

## Test plan
- Reset: drive reset low with prior data present -> dout=0x00, dout_n=0xFF, valid=0000, count=0, so_valid=0, without a clock edge.
- Write/read: write 0xA5@2, 0x3C@0 -> raddr=2 gives dout=0xA5, dout_n=0x5A. valid=0101, count=2. waddr out of range (DEPTH=3 build, waddr=3) -> no change.
- Shift fill: shift 0x11, 0x22, 0x33, 0x44 -> entry0..3 = 0x44, 0x33, 0x22, 0x11. count=4, so_valid never high. The fifth shift of 0x55 -> so_data=0x11, so_valid=1 for one cycle, count=4.
- Sparse shift: write 0x77@3 only, then shift 0x01 -> so_data=0x77, so_valid=1. The next shift -> so_valid=0 and so_data stays 0x77.
- Clear vs hold: after fill, mode=00 for 3 cycles -> no change. mode=11 -> valid=0000, count=0, all dout=0, so_data retained.
- Async reset mid-operation: assert reset between edges during a shift burst -> outputs zero immediately. After release, the first shift of 0x99 -> entry0=0x99, valid=0001.
